hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Pipeline hazard and sequencing controller for the 5-stage core; drives forwarding selects into the execute stage's two 3:1 operand muxes, and stall/flush controls into the fetch/decode/execute pipeline registers. Adds a multi-cycle execute sequencer (FSM + down-counter) that holds the pipeline while a long-latency execute op completes, and a saturating stall-cycle counter for performance monitoring.

Parameters:
MC_LAT, 4, total execute cycles of a multi-cycle op (>=1; 1 = no stall)
CNT_W, 16, width of the StallCount performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
Rs1D, Rs2D  in  5  decode-stage source registers
Rs1E, Rs2E, RdE  in  5  execute-stage source and destination registers
RdM, RdW  in  5  memory- and writeback-stage destinations
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage
ResultSrcE  in  1  execute instruction is a load
ALUSrcE  in  1  execute operand B is the immediate
MultiCycleE  in  1  execute instruction is a multi-cycle op
PCSrcE  in  1  branch taken in execute
ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALU_ResultM
StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX registers
FlushD, FlushE  out  1  clear IF-ID / ID-EX registers
BubbleM  out  1  gate RegWrite/MemWrite entering memory stage
ExecDoneE  out  1  multi-cycle op result valid this cycle
StallCount  out  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Reset (rst=1, async): state IDLE, cnt=0, StallCount=0; while rst=1 all control outputs are 0 and ForwardAE=ForwardBE=00.
- ForwardAE: 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. Memory-stage match wins over writeback match.
- ForwardBE: same rule on Rs2E, but forced 00 when ALUSrcE=1, because the B forwarding mux sits after the immediate mux.
- Combinational forwarding: zero latency, no registered outputs.
- Load-use: lwStall = ResultSrcE & RegWriteE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D). Sets StallF=StallD=1 and FlushE=1.
- Branch: PCSrcE=1 sets FlushD=1 and FlushE=1. Branch flush takes priority over lwStall: StallF=StallD=0 in that cycle.
- FSM states: IDLE, BUSY; cnt width = clog2(MC_LAT)+1.
  - IDLE, MultiCycleE=1, MC_LAT>1: mcStall=1; cnt<=MC_LAT-2; next state BUSY.
  - BUSY, cnt!=0: mcStall=1; cnt<=cnt-1.
  - BUSY, cnt==0: mcStall=0; ExecDoneE=1; next state IDLE.
  - IDLE, MultiCycleE=1, MC_LAT==1: ExecDoneE=1; no stall.
  - Result: exactly MC_LAT-1 stall cycles per op. Back-to-back multi-cycle ops re-enter BUSY from IDLE on the cycle after ExecDoneE.
- mcStall effects: StallF=StallD=StallE=1, BubbleM=1, FlushE=0, FlushD=0. mcStall overrides lwStall (no FlushE, so the op in execute is never killed).
- PCSrcE=1 while MultiCycleE=1 or state==BUSY is illegal; decode guarantees it cannot occur. Bench asserts it; RTL gives mcStall priority.
- StallCount increments on every cycle with StallF=1; it saturates at all-ones and does not wrap.
- Reset mid-BUSY: immediately returns to IDLE and deasserts all stalls; the in-flight op is discarded.

Decomposition:
- Package hazard_pkg:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - typedef enum mc_state_t {IDLE, BUSY}
- Sub-module forward_sel (combinational): per-operand forwarding decision, instantiated twice (A, and B with ALUSrcE masking).
- FSM, counters and stall/flush priority logic live in hazard_controller.

Test Plan:
- Forward priority: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Drop RegWriteM -> 01. RdM=RdW=0 -> 00.
- Immediate mask: Rs2E=RdM=7, RegWriteM=1, ALUSrcE=1 -> ForwardBE=00. ALUSrcE=0 -> 10.
- Load-use: ResultSrcE=1, RegWriteE=1, RdE=3, Rs2D=3 -> one cycle StallF=StallD=FlushE=1, StallCount 0->1. Add PCSrcE=1 same cycle -> FlushD=FlushE=1, StallF=0.
- Multi-cycle, MC_LAT=4: MultiCycleE pulse -> StallF/D/E=BubbleM=1 for 3 cycles, then ExecDoneE=1 for 1 cycle, StallCount=3. MultiCycleE held for a second op -> 3 more stall cycles.
- Reset mid-op: assert rst in second BUSY cycle -> same-cycle StallF=0, StallCount=0, state IDLE after release; MC_LAT=1 build -> ExecDoneE=1, no stall.
- Saturation: CNT_W=4, 20 consecutive stall cycles -> StallCount holds 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    // A later stage writes a non-x0 register that matches the given source.
    function automatic logic reg_hit(input logic we,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_sel.sv
// Per-operand forwarding select for one execute-stage operand mux.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rd_m_i,
    input  logic [REG_W-1:0] rd_w_i,
    input  logic             reg_write_m_i,
    input  logic             reg_write_w_i,
    input  logic             mask_i,
    output logic [FWD_W-1:0] fwd_c_o
);

    // Memory-stage producer is younger, so it wins over writeback.
    always_comb begin
        fwd_c_o = FWD_RF;
        if (!mask_i) begin
            if (reg_hit(reg_write_m_i, rd_m_i, rs_i)) begin
                fwd_c_o = FWD_MEM;
            end else if (reg_hit(reg_write_w_i, rd_w_i, rs_i)) begin
                fwd_c_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Forwarding, load-use/branch hazard control, multi-cycle execute sequencing
// and a saturating stall-cycle performance counter for the 5-stage core.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE,
    input  logic             ALUSrcE,
    input  logic             MultiCycleE,
    input  logic             PCSrcE,
    output logic [FWD_W-1:0] ForwardAE,
    output logic [FWD_W-1:0] ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             BubbleM,
    output logic             ExecDoneE,
    output logic [CNT_W-1:0] StallCount
);

    localparam int unsigned MC_CW    = $clog2(MC_LAT) + 1;
    localparam int unsigned MC_START = (MC_LAT > 1) ? (MC_LAT - 2) : 0;

    mc_state_t         state_q, state_d;
    logic [MC_CW-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              mc_stall_c;
    logic              exec_done_c;
    logic              lw_stall_c;
    logic              stall_f_c;
    logic [FWD_W-1:0]  fwd_a_c, fwd_b_c;

    forward_sel u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .mask_i        (1'b0),
        .fwd_c_o       (fwd_a_c)
    );

    // Operand B forwarding is meaningless when the immediate is selected.
    forward_sel u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .mask_i        (ALUSrcE),
        .fwd_c_o       (fwd_b_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Multi-cycle sequencer: the issuing cycle stalls too, so the counter
    // starts at MC_LAT-2 to give exactly MC_LAT-1 stall cycles per op.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mc_stall_c  = 1'b0;
        exec_done_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MultiCycleE) begin
                    if (MC_LAT > 1) begin
                        mc_stall_c = 1'b1;
                        cnt_d      = MC_CW'(MC_START);
                        state_d    = BUSY;
                    end else begin
                        exec_done_c = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mc_stall_c = 1'b1;
                    cnt_d      = cnt_q - MC_CW'(1);
                end else begin
                    exec_done_c = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lw_stall_c = ResultSrcE && RegWriteE && (RdE != '0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Priority: multi-cycle hold, then branch flush, then load-use stall.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        BubbleM   = 1'b0;
        ExecDoneE = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_a_c;
            ForwardBE = fwd_b_c;
            ExecDoneE = exec_done_c;
            if (mc_stall_c) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                BubbleM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall_c) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign stall_f_c   = StallF;
    assign stall_cnt_d = (stall_f_c && (stall_cnt_q != '1)) ?
                         stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign StallCount  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized self-checking bench for hazard_controller with three builds
// (MC_LAT=4/CNT_W=16, MC_LAT=1/CNT_W=16, MC_LAT=4/CNT_W=4) sharing stimulus.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       ResultSrcE, ALUSrcE, MultiCycleE, PCSrcE;

    logic [1:0]  fa [3];
    logic [1:0]  fb [3];
    logic        sf [3];
    logic        sd [3];
    logic        se [3];
    logic        fd [3];
    logic        fe [3];
    logic        bm [3];
    logic        ed [3];
    logic [15:0] sc0, sc1;
    logic [3:0]  sc2;

    int lat   [3] = '{4, 1, 4};
    int cmax  [3] = '{65535, 65535, 15};
    int age   [3] = '{-1, -1, -1};
    int cnt   [3] = '{0, 0, 0};
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MC_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE),
        .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE), .ForwardAE(fa[0]), .ForwardBE(fb[0]),
        .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]), .FlushD(fd[0]), .FlushE(fe[0]),
        .BubbleM(bm[0]), .ExecDoneE(ed[0]), .StallCount(sc0));

    hazard_controller #(.MC_LAT(1), .CNT_W(16)) dut_lat1 (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE),
        .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE), .ForwardAE(fa[1]), .ForwardBE(fb[1]),
        .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]), .FlushD(fd[1]), .FlushE(fe[1]),
        .BubbleM(bm[1]), .ExecDoneE(ed[1]), .StallCount(sc1));

    hazard_controller #(.MC_LAT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE),
        .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE), .ForwardAE(fa[2]), .ForwardBE(fb[2]),
        .StallF(sf[2]), .StallD(sd[2]), .StallE(se[2]), .FlushD(fd[2]), .FlushE(fe[2]),
        .BubbleM(bm[2]), .ExecDoneE(ed[2]), .StallCount(sc2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Forwarding rule straight from the operand-source definition.
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic mask);
        if (rst || mask) return 2'b00;
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ALUSrcE, MultiCycleE, PCSrcE} = '0;
    endtask

    // Inputs are applied just after a rising edge; check mid-cycle, then
    // advance the reference model across the coming edge.
    task automatic step();
        int          cur;
        logic        lw, stall, done;
        logic [8:0]  exp_ctl;
        logic [31:0] got_cnt;
        #4;
        assert (!(PCSrcE && (MultiCycleE || age[0] >= 0)))
            else $error("illegal branch during multi-cycle op");
        lw = ResultSrcE && RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                age[i] = -1;
                cnt[i] = 0;
            end
            // age = cycles elapsed since the op entered execute
            cur  = (age[i] < 0 && MultiCycleE) ? 0 : age[i];
            stall = !rst && cur >= 0 && cur < lat[i] - 1;
            done  = !rst && cur == lat[i] - 1;
            // {StallF,StallD,StallE,FlushD,FlushE,BubbleM}
            exp_ctl = '0;
            if (rst)           exp_ctl[5:0] = 6'b000000;
            else if (stall)    exp_ctl[5:0] = 6'b111001;
            else if (PCSrcE)   exp_ctl[5:0] = 6'b000110;
            else if (lw)       exp_ctl[5:0] = 6'b110010;
            got_cnt = (i == 0) ? 32'(sc0) : (i == 1) ? 32'(sc1) : 32'(sc2);
            check($sformatf("ForwardAE[%0d]", i), 32'(fa[i]), 32'(ref_fwd(Rs1E, 1'b0)));
            check($sformatf("ForwardBE[%0d]", i), 32'(fb[i]), 32'(ref_fwd(Rs2E, ALUSrcE)));
            check($sformatf("StallF[%0d]", i), 32'(sf[i]), 32'(exp_ctl[5]));
            check($sformatf("StallD[%0d]", i), 32'(sd[i]), 32'(exp_ctl[4]));
            check($sformatf("StallE[%0d]", i), 32'(se[i]), 32'(exp_ctl[3]));
            check($sformatf("FlushD[%0d]", i), 32'(fd[i]), 32'(exp_ctl[2]));
            check($sformatf("FlushE[%0d]", i), 32'(fe[i]), 32'(exp_ctl[1]));
            check($sformatf("BubbleM[%0d]", i), 32'(bm[i]), 32'(exp_ctl[0]));
            check($sformatf("ExecDoneE[%0d]", i), 32'(ed[i]), 32'(done));
            check($sformatf("StallCount[%0d]", i), got_cnt, 32'(cnt[i]));
            if (!rst) begin
                if (exp_ctl[5] && cnt[i] < cmax[i]) cnt[i]++;
                if (cur >= 0) age[i] = (cur == lat[i] - 1) ? -1 : cur + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        ResultSrcE = 1'b1; RegWriteE = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        step();
        step();
        rst = 1'b0;
        step();

        // forwarding priority and x0 / immediate masking
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
        step();
        RegWriteM = 1'b0;
        step();
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
        step();
        clear_inputs();
        Rs2E = 5'd7; RdM = 5'd7; RegWriteM = 1'b1; ALUSrcE = 1'b1;
        step();
        ALUSrcE = 1'b0;
        step();
        clear_inputs();

        // load-use alone, then with a taken branch
        set_load_use();
        step();
        PCSrcE = 1'b1;
        step();
        clear_inputs();
        step();

        // single multi-cycle op, then back-to-back ops
        MultiCycleE = 1'b1;
        step();
        MultiCycleE = 1'b0;
        repeat (4) step();
        MultiCycleE = 1'b1;
        repeat (8) step();
        clear_inputs();
        step();

        // reset in the second busy cycle
        MultiCycleE = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        MultiCycleE = 1'b0;
        step();
        MultiCycleE = 1'b1;
        step();
        clear_inputs();
        repeat (4) step();

        // saturation of the narrow counter
        set_load_use();
        repeat (20) step();
        check("sat_hold", 32'(sc2), 32'd15);
        clear_inputs();
        step();

        repeat (400) begin
            rst         = ($urandom_range(0, 99) == 0);
            Rs1D        = 5'($urandom_range(0, 3));
            Rs2D        = 5'($urandom_range(0, 3));
            Rs1E        = 5'($urandom_range(0, 3));
            Rs2E        = 5'($urandom_range(0, 3));
            RdE         = 5'($urandom_range(0, 3));
            RdM         = 5'($urandom_range(0, 3));
            RdW         = 5'($urandom_range(0, 3));
            RegWriteE   = 1'($urandom);
            RegWriteM   = 1'($urandom);
            RegWriteW   = 1'($urandom);
            ResultSrcE  = 1'($urandom);
            ALUSrcE     = 1'($urandom);
            MultiCycleE = ($urandom_range(0, 7) == 0);
            PCSrcE      = ($urandom_range(0, 3) == 0) && !MultiCycleE && age[0] < 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
